// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared definitions for the CS_RISC bring-up logic: default
//               instruction/address widths (matching the core) and the boot
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  // Default widths shared with the CS_RISC core.
  localparam int RISC_INSTR_WIDTH = 32;
  localparam int RISC_ADDR_WIDTH  = 10;

  // Boot sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALTED  = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/risc_halt_detector.sv
`default_nettype none
// ============================================================================
// Module      : risc_halt_detector
// Description : Detects a core halt as a program counter that stays unchanged
//               for HALT_CYCLES consecutive cycles.
// Revision    : 1.0 - initial release
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               en_i    - compare/track the PC this cycle
//               clr_i   - forget PC history and clear the stable count
//               pc_i    - core program counter
//               hit_o   - combinational: this cycle completes the stable run
// ============================================================================
module risc_halt_detector #(
  parameter int ADDR_WIDTH  = risc_pkg::RISC_ADDR_WIDTH,
  parameter int HALT_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  hit_o
);

  localparam int CW = $clog2(HALT_CYCLES + 1);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  pc_vld_q;
  logic [CW-1:0]         stable_q;
  logic [CW-1:0]         stable_d;
  logic                  same;

  // The first tracked cycle has no predecessor, so it never counts as stable.
  assign same = pc_vld_q && (pc_i == pc_q);

  // Hit is raised in the cycle whose comparison brings the count to
  // HALT_CYCLES, so the sequencer can leave RUN on that same edge.
  assign hit_o = en_i && !clr_i && same && (stable_q == CW'(HALT_CYCLES - 1));

  always_comb begin
    stable_d = stable_q;
    if (clr_i) begin
      stable_d = '0;
    end else if (en_i) begin
      if (!same) begin
        stable_d = '0;
      end else if (stable_q != CW'(HALT_CYCLES)) begin
        stable_d = stable_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= '0;
      pc_vld_q <= 1'b0;
      stable_q <= '0;
    end else begin
      stable_q <= stable_d;
      if (clr_i) begin
        pc_vld_q <= 1'b0;
      end else if (en_i) begin
        pc_q     <= pc_i;
        pc_vld_q <= 1'b1;
      end
    end
  end

endmodule : risc_halt_detector
`default_nettype wire

// File: rtl/risc_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : risc_boot_sequencer
// Description : Bring-up controller for CS_RISC. Streams a program into
//               instruction memory, holds the core in reset for RESET_CYCLES,
//               releases it and watches for halt (PC self-loop) or watchdog.
// Revision    : 1.0 - initial release
// Ports       : clk_i/rst_ni           - clock, async active-low reset
//               start_i                - pulse to begin load/run
//               ld_valid_i/ld_ready_o  - program load handshake
//               ld_data_i/ld_last_i    - load word and end-of-program marker
//               imem_we_o/addr_o/wdata_o - instruction-memory write port
//               cpu_reset_o            - active-high core reset
//               cpu_pc_i               - core program counter
//               busy_o/halted_o/timeout_o/overflow_o - status
//               run_cycles_o           - cycles spent in RUN
// ============================================================================
module risc_boot_sequencer
  import risc_pkg::*;
#(
  parameter int INSTR_WIDTH     = RISC_INSTR_WIDTH,
  parameter int ADDR_WIDTH      = RISC_ADDR_WIDTH,
  parameter int RESET_CYCLES    = 25,
  parameter int HALT_CYCLES     = 8,
  parameter int WATCHDOG_CYCLES = 100000,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  input  logic [INSTR_WIDTH-1:0] ld_data_i,
  input  logic                   ld_last_i,
  output logic                   imem_we_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  output logic [INSTR_WIDTH-1:0] imem_wdata_o,
  output logic                   cpu_reset_o,
  input  logic [ADDR_WIDTH-1:0]  cpu_pc_i,
  output logic                   busy_o,
  output logic                   halted_o,
  output logic                   timeout_o,
  output logic                   overflow_o,
  output logic [CNT_WIDTH-1:0]   run_cycles_o
);

  localparam int HW = $clog2(RESET_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   ld_ready_q, ld_ready_d;
  logic                   imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
  logic [INSTR_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic                   timeout_q, timeout_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]   run_cycles_q, run_cycles_d;
  logic                   halt_hit;

  risc_halt_detector #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt_det (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == ST_RUN),
    .clr_i  (state_q == ST_HOLD),
    .pc_i   (cpu_pc_i),
    .hit_o  (halt_hit)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    ld_ready_d   = ld_ready_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;
    run_cycles_d = run_cycles_q;

    unique case (state_q)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        if (state_q == ST_IDLE) begin
          cpu_reset_d  = 1'b1;
          ld_ready_d   = 1'b0;
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
          overflow_d   = 1'b0;
          run_cycles_d = '0;
          ptr_d        = '0;
        end
        if (start_i) begin
          state_d      = ST_LOAD;
          cpu_reset_d  = 1'b1;
          ld_ready_d   = 1'b0;   // ready rises one cycle after LOAD entry
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
          overflow_d   = 1'b0;
          run_cycles_d = '0;
          ptr_d        = '0;
        end
      end
      ST_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_valid_i && ld_ready_q) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ptr_q;
          imem_wdata_d = ld_data_i;
          ptr_d        = ptr_q + ADDR_WIDTH'(1);
          // Last word, or the final address taken without an end marker.
          if (ld_last_i || (ptr_q == '1)) begin
            overflow_d = !ld_last_i;
            state_d    = ST_HOLD;
            ld_ready_d = 1'b0;
            hold_d     = '0;
          end
        end
      end
      ST_HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(RESET_CYCLES - 1)) begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!(&run_cycles_q)) begin
          run_cycles_d = run_cycles_q + CNT_WIDTH'(1);
        end
        // Halt takes priority over a watchdog expiring on the same cycle.
        if (halt_hit) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (run_cycles_d == CNT_WIDTH'(WATCHDOG_CYCLES)) begin
          state_d     = ST_TIMEOUT;
          timeout_d   = 1'b1;
          cpu_reset_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cpu_reset_d = 1'b1;
        ld_ready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_HOLD) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      hold_q       <= '0;
      ld_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      ld_ready_q   <= ld_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign ld_ready_o   = ld_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign busy_o       = busy_q;
  assign halted_o     = halted_q;
  assign timeout_o    = timeout_q;
  assign overflow_o   = overflow_q;
  assign run_cycles_o = run_cycles_q;

endmodule : risc_boot_sequencer
`default_nettype wire

// File: tb/tb_risc_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_boot_sequencer
// Description : Self-checking bench for risc_boot_sequencer. A small
//               instance (8-word memory, 50-cycle watchdog) is taken through
//               several load/hold/run sequences; expected halt/timeout points
//               are derived from the driven PC trace by a window scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_boot_sequencer;

  localparam int IW  = 32;
  localparam int AW  = 3;
  localparam int RST = 25;
  localparam int HLT = 8;
  localparam int WD  = 50;
  localparam int CW  = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          cpu_reset;
  logic [AW-1:0] cpu_pc;
  logic          busy;
  logic          halted;
  logic          timeout;
  logic          overflow;
  logic [CW-1:0] run_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [IW-1:0] words [8];
  logic [AW-1:0] pcs   [64];

  risc_boot_sequencer #(
    .INSTR_WIDTH     (IW),
    .ADDR_WIDTH      (AW),
    .RESET_CYCLES    (RST),
    .HALT_CYCLES     (HLT),
    .WATCHDOG_CYCLES (WD),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_data_i    (ld_data),
    .ld_last_i    (ld_last),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .cpu_reset_o  (cpu_reset),
    .cpu_pc_i     (cpu_pc),
    .busy_o       (busy),
    .halted_o     (halted),
    .timeout_o    (timeout),
    .overflow_o   (overflow),
    .run_cycles_o (run_cycles)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, {ld_ready, imem_we, cpu_reset, busy, halted, timeout, overflow}, 7'b0010000);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_runcyc"}, run_cycles, 0);
  endtask

  // Start pulse, then an offered word during the LOAD entry cycle that must
  // not be accepted because ready is still low.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_flags", {busy, ld_ready, cpu_reset, halted, timeout, overflow}, 6'b101000);
    chk("start_runcyc", run_cycles, 0);
    chk("start_we", imem_we, 0);
    ld_valid = 1'b1;
    ld_data  = $urandom;
    ld_last  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("entry_nowrite", imem_we, 0);
    chk("entry_ready", ld_ready, 1);
  endtask

  task automatic do_load(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int ng;
      ng = gaps ? int'($urandom_range(1, 2)) : 0;
      for (int g = 0; g < ng; g++) begin
        start = ($urandom_range(0, 1) == 1);
        tick();
        start = 1'b0;
        chk("gap_nowrite", imem_we, 0);
        chk("gap_ready_busy", {ld_ready, busy}, 2'b11);
      end
      ld_valid = 1'b1;
      ld_data  = words[i];
      ld_last  = use_last && (i == n - 1);
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("wr_en", imem_we, 1);
      chk("wr_addr", imem_addr, i);
      chk("wr_data", imem_wdata, words[i]);
      if (i == n - 1) begin
        chk("hold_entry", {ld_ready, busy, cpu_reset}, 3'b011);
        chk("overflow", overflow, !use_last);
      end else begin
        chk("load_ready", ld_ready, 1);
      end
    end
  endtask

  // Counts cycles with cpu_reset high starting at the HOLD entry cycle.
  task automatic do_hold();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!cpu_reset) break;
      cnt++;
      start = (i == 3);
      tick();
      start = 1'b0;
    end
    chk("hold_len", cnt, RST);
    chk("run_entry", {busy, imem_we, halted, timeout}, 4'b1000);
  endtask

  // Window of HLT+1 identical PCs ending at run cycle k.
  function automatic bit win_eq(input int k);
    for (int t = 1; t <= HLT; t++) begin
      if (pcs[k - 1 - t] != pcs[k - 1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic do_run();
    int kend;
    bit exph;
    kend = WD;
    exph = 1'b0;
    for (int k = HLT + 1; k <= WD; k++) begin
      if (!exph && win_eq(k)) begin
        exph = 1'b1;
        kend = k;
      end
    end
    for (int k = 1; k <= kend; k++) begin
      cpu_pc = pcs[k - 1];
      start  = ($urandom_range(0, 5) == 0);
      tick();
      start  = 1'b0;
      if (k < kend) begin
        chk("run_cyc", run_cycles, k);
        chk("run_flags", {halted, timeout, busy, cpu_reset}, 4'b0010);
      end
    end
    chk("end_cyc", run_cycles, kend);
    chk("end_flags", {halted, timeout, busy, cpu_reset}, {exph, !exph, 1'b0, !exph});
    for (int j = 0; j < 3; j++) begin
      cpu_pc = AW'($urandom);
      tick();
      chk("frozen_cyc", run_cycles, kend);
      chk("frozen_flags", {halted, timeout, busy}, {exph, !exph, 1'b0});
    end
  endtask

  task automatic gen_pcs();
    logic [AW-1:0] p;
    p = AW'($urandom);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) p = AW'($urandom);
      pcs[i] = p;
    end
  endtask

  task automatic gen_words();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
  endtask

  initial begin
    logic [AW-1:0] pa, pb;
    rst_n    = 1'b0;
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    cpu_pc   = '0;
    repeat (3) tick();
    chk_reset("por");
    rst_n = 1'b1;
    tick();
    chk("idle", {busy, cpu_reset, ld_ready}, 3'b010);

    // Basic load of four fixed words, then the 0,1,2,3,3,... halt trace.
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    do_start();
    do_load(4, 1'b1, 1'b0);
    do_hold();
    for (int i = 0; i < 64; i++) pcs[i] = (i < 4) ? AW'(i) : AW'(3);
    do_run();

    // Rerun from HALTED with backpressure gaps and random PC trace.
    gen_words();
    do_start();
    do_load(6, 1'b1, 1'b1);
    do_hold();
    gen_pcs();
    do_run();

    // Watchdog: PC toggles every cycle, so no halt is possible.
    gen_words();
    do_start();
    do_load(3, 1'b1, 1'b1);
    do_hold();
    pa = AW'($urandom);
    pb = pa ^ AW'($urandom_range(1, 7));
    for (int i = 0; i < 64; i++) pcs[i] = i[0] ? pb : pa;
    do_run();

    // Overflow: fill all eight words without an end marker (from TIMEOUT).
    gen_words();
    do_start();
    do_load(8, 1'b0, 1'b1);
    do_hold();
    gen_pcs();
    do_run();

    // Asynchronous abort in the middle of a load.
    gen_words();
    do_start();
    ld_valid = 1'b1;
    ld_data  = words[0];
    tick();
    ld_valid = 1'b0;
    chk("abort_pre_wr", {imem_we, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    repeat (2) tick();
    chk_reset("abort_held");
    rst_n = 1'b1;
    tick();
    chk("abort_idle", {busy, cpu_reset, ld_ready}, 3'b010);

    // Fresh sequence after the abort restarts at address zero.
    gen_words();
    do_start();
    do_load(5, 1'b1, 1'b1);
    do_hold();
    gen_pcs();
    do_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_risc_boot_sequencer
`default_nettype wire
